// File: rtl/fp_iterative_divider.sv
`default_nettype none
// ============================================================================
// fp_iterative_divider : sequential IEEE-754 single-precision divider
//   (restoring division, one quotient bit per clock, truncating pack)
// Revision 1.0
// ============================================================================
module fp_iterative_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, NORM = 2'd2} state_t;

  localparam logic [31:0] C_QNAN = 32'h7FC0_0000;

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [31:0]        result_q, result_d;
  logic               dz_q, dz_d;
  logic [24:0]        r_q, r_d;
  logic [24:0]        q_q, q_d;
  logic [23:0]        mb_q, mb_d;
  logic signed [9:0]  ex_q, ex_d;
  logic               sign_q, sign_d;
  logic [4:0]         count_q, count_d;
  logic               spec_pend_q, spec_pend_d;
  logic [31:0]        spec_res_q, spec_res_d;
  logic               spec_dz_q, spec_dz_d;

  logic               a_ezero, b_ezero, a_emax, b_emax;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [7:0]         ea, eb;
  logic [23:0]        ma, mb;
  logic signed [9:0]  ex_in;
  logic               sign_in;
  logic               spec_hit, spec_dz;
  logic [31:0]        spec_val;
  logic               r_ge;
  logic [24:0]        r_rem;
  logic [31:0]        packed_val;

  assign a_ezero = ~|a[30:23];
  assign b_ezero = ~|b[30:23];
  assign a_emax  = &a[30:23];
  assign b_emax  = &b[30:23];
  assign a_nan   = a_emax & (|a[22:0]);
  assign b_nan   = b_emax & (|b[22:0]);
  assign a_inf   = a_emax & ~(|a[22:0]);
  assign b_inf   = b_emax & ~(|b[22:0]);
  assign a_zero  = a_ezero & ~(|a[22:0]);
  assign b_zero  = b_ezero & ~(|b[22:0]);
  assign ea      = a_ezero ? 8'd1 : a[30:23];
  assign eb      = b_ezero ? 8'd1 : b[30:23];
  assign ma      = {~a_ezero, a[22:0]};
  assign mb      = {~b_ezero, b[22:0]};
  assign ex_in   = {2'b00, ea} - {2'b00, eb} + 10'sd127;
  assign sign_in = a[31] ^ b[31];

  // Special-operand priority: NaN, inf/inf, 0/0, inf/x, x/0, 0/x, x/inf.
  always_comb begin
    spec_hit = 1'b1;
    spec_dz  = 1'b0;
    spec_val = C_QNAN;
    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
      spec_val = C_QNAN;
    end else if (a_inf) begin
      spec_val = {sign_in, 8'hFF, 23'd0};
    end else if (b_zero) begin
      spec_val = {sign_in, 8'hFF, 23'd0};
      spec_dz  = 1'b1;
    end else if (a_zero || b_inf) begin
      spec_val = {sign_in, 31'd0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  assign r_ge  = r_q >= {1'b0, mb_q};
  assign r_rem = r_ge ? (r_q - {1'b0, mb_q}) : r_q;

  always_comb begin
    if (ex_q >= 10'sd255) begin
      packed_val = {sign_q, 8'hFF, 23'd0};
    end else if (ex_q < 10'sd1) begin
      packed_val = {sign_q, 31'd0};
    end else begin
      packed_val = {sign_q, (q_q[24] ? ex_q[7:0] : 8'd0), q_q[23:1]};
    end
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    result_d    = result_q;
    dz_d        = dz_q;
    r_d         = r_q;
    q_d         = q_q;
    mb_d        = mb_q;
    ex_d        = ex_q;
    sign_d      = sign_q;
    count_d     = count_q;
    spec_pend_d = spec_pend_q;
    spec_res_d  = spec_res_q;
    spec_dz_d   = spec_dz_q;
    case (state_q)
      IDLE: begin
        if (spec_pend_q) begin
          // Special results are held one cycle so they complete with latency 1.
          result_d    = spec_res_q;
          dz_d        = spec_dz_q;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          spec_pend_d = 1'b0;
        end else if (start && !busy_q) begin
          busy_d  = 1'b1;
          sign_d  = sign_in;
          ex_d    = ex_in;
          mb_d    = mb;
          r_d     = {1'b0, ma};
          q_d     = 25'd0;
          count_d = 5'd0;
          if (spec_hit) begin
            spec_pend_d = 1'b1;
            spec_res_d  = spec_val;
            spec_dz_d   = spec_dz;
          end else begin
            state_d = DIV;
          end
        end
      end
      DIV: begin
        r_d     = r_rem << 1;
        q_d     = {q_q[23:0], r_ge};
        count_d = count_q + 5'd1;
        if (count_q == 5'd24) begin
          state_d = NORM;
        end
      end
      NORM: begin
        if (!q_q[24] && (ex_q > 10'sd1)) begin
          q_d  = q_q << 1;
          ex_d = ex_q - 10'sd1;
        end else begin
          result_d = packed_val;
          dz_d     = 1'b0;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= 32'd0;
      dz_q        <= 1'b0;
      r_q         <= 25'd0;
      q_q         <= 25'd0;
      mb_q        <= 24'd0;
      ex_q        <= 10'sd0;
      sign_q      <= 1'b0;
      count_q     <= 5'd0;
      spec_pend_q <= 1'b0;
      spec_res_q  <= 32'd0;
      spec_dz_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      dz_q        <= dz_d;
      r_q         <= r_d;
      q_q         <= q_d;
      mb_q        <= mb_d;
      ex_q        <= ex_d;
      sign_q      <= sign_d;
      count_q     <= count_d;
      spec_pend_q <= spec_pend_d;
      spec_res_q  <= spec_res_d;
      spec_dz_q   <= spec_dz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign div_by_zero = dz_q;

endmodule
`default_nettype wire

// File: doc/fp_iterative_divider.md
Name: fp_iterative_divider

Overview:
- Sequential IEEE-754 single-precision divider; computes result = a / b.
- Inverse companion to the ALU's combinational FP multiplier: same unpacking rules, same truncating (no rounding) mantissa policy.
- Uses restoring division, one quotient bit per clock, followed by a left-normalization loop.
- Sits in the ALU datapath beside the multiplier, driven by a start/done handshake.

Parameters:
- none (format fixed at 1 sign / 8 exponent / 23 fraction bits, bias 127).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only while busy=0.
- a  input  32  dividend, IEEE-754 single.
- b  input  32  divisor, IEEE-754 single.
- busy  output  1  high from the start-accept edge until the edge that asserts done.
- done  output  1  registered single-cycle pulse when result is updated.
- result  output  32  quotient; holds its value until the next done.
- div_by_zero  output  1  registered with result; 1 when b is ±0 and a is finite nonzero.

Behaviour:
- Reset: synchronous, active-high, applies at any state including mid-division.
  - On reset: state=IDLE, busy=0, done=0, result=0x00000000, div_by_zero=0, all internal registers cleared.
- Unpack (at the start-accept edge):
  - Exponent field 0: E=1, mantissa = {0, frac} (denormal).
  - Otherwise: E = field, mantissa = {1, frac}.
  - Sign = a[31] ^ b[31].
  - Ex = EA - EB + 127, computed signed 10-bit.
- States: IDLE, DIV, NORM.
  - In IDLE with start=1: latch the operands, then check specials in this priority order.
    - a NaN or b NaN -> 0x7FC00000.
    - inf/inf -> 0x7FC00000.
    - 0/0 -> 0x7FC00000.
    - inf/x -> signed inf.
    - x/0 -> signed inf, div_by_zero=1.
    - 0/x -> signed zero.
    - x/inf -> signed zero.
  - A special writes result and done at the next edge (latency 1) and stays in IDLE. Otherwise go to DIV with R=MA, Q=0, count=0.
- DIV: 25 cycles, count 0..24.
  - Each cycle: if R>=MB then {R=R-MB, qbit=1} else qbit=0.
  - Then Q={Q[23:0],qbit} and R=R<<1.
  - R is 25 bits wide.
  - After count=24, go to NORM.
  - Q[24] carries weight 1.0.
- NORM: one action per cycle.
  - If Q[24]=0 and Ex>1: Q=Q<<1, Ex=Ex-1, stay in NORM.
  - Else pack and go to IDLE, asserting done for one cycle:
    - Ex>=255 -> signed inf (0x7F800000 | sign<<31).
    - Ex<1 -> signed zero (flush, no denormal output).
    - Otherwise: exponent field = Q[24] ? Ex[7:0] : 0, fraction = Q[23:1], truncated.
- Latency from the start-accept edge to the done edge:
  - Normal operands with MA>=MB: 26 clocks.
  - Normal operands with MA<MB: 27 clocks.
  - Denormal inputs: up to 26+24 clocks.
- Handshake:
  - start while busy=1 is ignored and does not disturb the operation in flight.
  - start on the same edge that done is asserted is ignored; start is accepted from the next cycle.
  - done never coincides with busy=1.
- a and b may change freely after the accept edge; they are latched.
- div_by_zero is 0 for every result except x/0.

Test Plan:
- a=0x40C00000 (6.0), b=0x40000000 (2.0) -> result 0x40400000, done exactly 26 clocks after accept, busy high for those 26 cycles.
- a=0x3F800000, b=0x40400000 (1/3) -> result 0x3EAAAAAA (truncated), latency 27; a second start pulsed mid-division is ignored.
- Specials:
  - a=0xC0000000, b=0x00000000 -> 0xFF800000 with div_by_zero=1, latency 1.
  - a=0, b=0 -> 0x7FC00000.
  - a=0x7F800000, b=0x3F800000 -> 0x7F800000.
- Range limits:
  - a=0x7F000000, b=0x3E800000 -> overflow 0x7F800000.
  - a=0x00800000, b=0x40000000 -> flushed 0x00000000.
- Denormal input: a=0x00400000, b=0x3F000000 -> 0x00800000, latency 27.
- Reset: assert rst at DIV count 10 -> next cycle busy=0, done=0, result=0; a fresh 6.0/2.0 then completes normally.
